// File: rtl/conc_stim_player_if.sv
// Opcode load port for conc_stim_player.
// Host drives valid/data/last; the player returns ready.
interface conc_stim_player_if #(
  parameter int DATA_W = 6
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W+1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/conc_stim_player.sv
// Opcode playback stage driving DUT primary inputs.
// CONC_STIM_LOOP_EN: wrap to the first opcode instead of stopping.
module conc_stim_player #(
  parameter int DEPTH  = 201,
  parameter int DATA_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  conc_stim_player_if.slave ld,
  input  logic              start,
  input  logic              clr,
  output logic [DATA_W-1:0] x_in,
  output logic              stbi,
  output logic              obs,
  output logic [31:0]       pc,
  output logic              busy,
  output logic              done,
  output logic              wrap
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int OW = DATA_W + 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [LW-1:0] WP_MAX  = LW'(DEPTH);
  localparam logic [LW-1:0] WP_LAST = LW'(DEPTH - 1);

  logic [1:0]    state;
  logic [LW-1:0] wp;
  logic [LW-1:0] len;
  logic [OW-1:0] mem [DEPTH];
  logic [OW-1:0] op;
  logic          ld_fire;
  logic          seal;
  logic          at_end;
  logic          sealed;

  assign sealed = (len != '0);

  assign ld.ld_ready = !reset
                    && (state == S_IDLE)
                    && !sealed
                    && (wp < WP_MAX);

  assign ld_fire = ld.ld_valid & ld.ld_ready;
  assign seal    = ld_fire
                && (ld.ld_last || wp == WP_LAST);
  assign at_end  = (pc == 32'(len));

  always_ff @(posedge clock) begin
    if (ld_fire && !clr) mem[wp] <= ld.ld_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      wp    <= '0;
      len   <= '0;
      pc    <= '0;
      op    <= '0;
    end else if (clr) begin
      state <= S_IDLE;
      wp    <= '0;
      len   <= '0;
      pc    <= '0;
      op    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ld_fire) wp <= wp + LW'(1);
          if (seal) len <= wp + LW'(1);
          if (start && sealed) begin
            state <= S_RUN;
            pc    <= 32'd1;
            op    <= mem[0];
          end
        end
        S_RUN: begin
          if (at_end) begin
`ifdef CONC_STIM_LOOP_EN
            pc <= 32'd1;
            op <= mem[0];
`else
            state <= S_DONE;
            pc    <= '0;
            op    <= '0;
`endif
          end else begin
            // pc is 1-based, so slot pc is the next opcode
            pc <= pc + 32'd1;
            op <= mem[pc[LW-1:0]];
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_RUN;
            pc    <= 32'd1;
            op    <= mem[0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CONC_STIM_LOOP_EN
  always_ff @(posedge clock) begin
    if (reset) wrap <= 1'b0;
    else wrap <= !clr && (state == S_RUN) && at_end;
  end
`else
  assign wrap = 1'b0;
`endif

  assign x_in = op[DATA_W-1:0];
  assign stbi = op[DATA_W];
  assign obs  = op[DATA_W+1];
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_conc_stim_player.sv
// Directed bench for conc_stim_player.
// Single-pass scenarios by default; loop scenario with CONC_STIM_LOOP_EN.
module tb_conc_stim_player;
  localparam int DEPTH  = 201;
  localparam int DATA_W = 6;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              clr;
  logic [DATA_W-1:0] x_in;
  logic              stbi;
  logic              obs;
  logic [31:0]       pc;
  logic              busy;
  logic              done;
  logic              wrap;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q [$];

  conc_stim_player_if #(.DATA_W(DATA_W)) ld_if ();

  conc_stim_player #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ld    (ld_if),
    .start (start),
    .clr   (clr),
    .x_in  (x_in),
    .stbi  (stbi),
    .obs   (obs),
    .pc    (pc),
    .busy  (busy),
    .done  (done),
    .wrap  (wrap)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] outv();
    return {24'd0, obs, stbi, x_in};
  endfunction

  task automatic load_q(input bit use_last);
    for (int i = 0; i < q.size(); i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = q[i];
      ld_if.ld_last  = use_last && (i == q.size() - 1);
      tick();
    end
    ld_if.ld_valid = 1'b0;
    ld_if.ld_last  = 1'b0;
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    clr   = 1'b0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    ld_if.ld_last  = 1'b0;
    tick();
    chk("rst_ready", 32'(ld_if.ld_ready), 0);
    chk("rst_pc", pc, 0);
    chk("rst_out", outv(), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;
    #1;
    chk("idle_ready", 32'(ld_if.ld_ready), 1);

`ifdef CONC_STIM_LOOP_EN
    q = '{8'h81, 8'h03};
    load_q(1'b1);
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      chk("loop_pc", pc, (c % 2 == 0) ? 1 : 2);
      chk("loop_out", outv(),
          (c % 2 == 0) ? 32'h81 : 32'h03);
      chk("loop_wrap", 32'(wrap),
          (c > 0 && c % 2 == 0) ? 1 : 0);
      chk("loop_done", 32'(done), 0);
      chk("loop_busy", 32'(busy), 1);
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("loop_clr_pc", pc, 0);
    chk("loop_clr_busy", 32'(busy), 0);
`else
    pulse_start();
    chk("empty_busy", 32'(busy), 0);
    chk("empty_pc", pc, 0);

    q = '{8'hC1, 8'h45, 8'h02};
    load_q(1'b1);
    chk("seal_ready", 32'(ld_if.ld_ready), 0);
    pulse_start();
    chk("p1_pc", pc, 1);
    chk("p1_out", outv(), 32'hC1);
    chk("p1_busy", 32'(busy), 1);
    tick();
    chk("p2_pc", pc, 2);
    chk("p2_out", outv(), 32'h45);
    tick();
    chk("p3_pc", pc, 3);
    chk("p3_out", outv(), 32'h02);
    tick();
    chk("d_done", 32'(done), 1);
    chk("d_pc", pc, 0);
    chk("d_out", outv(), 0);
    chk("d_busy", 32'(busy), 0);

    pulse_start();
    chk("r1_pc", pc, 1);
    chk("r1_out", outv(), 32'hC1);
    start = 1'b1;
    tick();
    chk("r2_pc", pc, 2);
    chk("r2_out", outv(), 32'h45);
    tick();
    start = 1'b0;
    chk("r3_pc", pc, 3);
    chk("r3_out", outv(), 32'h02);
    tick();
    chk("r_done", 32'(done), 1);

    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_pc", pc, 0);
    chk("clr_ready", 32'(ld_if.ld_ready), 1);

    q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    load_q(1'b1);
    pulse_start();
    tick();
    chk("rr_pc2", pc, 2);
    chk("rr_out2", outv(), 32'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_pc", pc, 0);
    chk("rr_out", outv(), 0);
    chk("rr_busy", 32'(busy), 0);
    pulse_start();
    chk("rr_ign_busy", 32'(busy), 0);
    chk("rr_ign_pc", pc, 0);

    q.delete();
    for (int i = 0; i < DEPTH; i++) q.push_back(8'(i * 3 + 7));
    for (int i = 0; i < DEPTH; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = q[i];
      ld_if.ld_last  = 1'b0;
      #1;
      if (i == DEPTH - 1)
        chk("full_rdy_pre", 32'(ld_if.ld_ready), 1);
      tick();
    end
    ld_if.ld_valid = 1'b0;
    #1;
    chk("full_rdy_post", 32'(ld_if.ld_ready), 0);
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_pc", pc, 32'(i + 1));
      chk("full_out", outv(), 32'(q[i]));
      tick();
    end
    chk("full_done", 32'(done), 1);
    chk("full_end_pc", pc, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/conc_stim_player.md
# conc_stim_player

Synthesizable opcode playback stage that sits directly upstream of the DUT in the concolic harness and drives its primary inputs. A host side loads a sequence of 8-bit opcodes into an internal buffer through a valid/ready port. On `start`, one opcode per clock is replayed, decoded into `x_in`, `stbi` and `obs`, and the 1-based program counter is exposed for trace correlation.

## Interface
- `DEPTH`, 201: opcode buffer entries.
- `DATA_W`, 6: width of `x_in`; opcode width is `DATA_W+2`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_valid` in 1: load request.
- `ld_ready` out 1: load accepted this cycle when `ld_valid & ld_ready`.
- `ld_data` in `DATA_W+2`: opcode; bit `DATA_W+1` = obs, bit `DATA_W` = stbi, `[DATA_W-1:0]` = x_in.
- `ld_last` in 1: marks the final opcode of the sequence.
- `start` in 1: begin playback.
- `clr` in 1: discard the loaded sequence and return to IDLE.
- `x_in` out `DATA_W`: DUT data input.
- `stbi` out 1: DUT strobe.
- `obs` out 1: observation marker.
- `pc` out 32: 1-based index of the opcode on the outputs; 0 when not playing.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `wrap` out 1: one-cycle pulse on loop wrap.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, `len`=0, `wp`=0, `pc`=0, `x_in`/`stbi`/`obs`=0, `busy`/`done`/`wrap`=0, `ld_ready`=0 in the reset cycle. Buffer contents are not reset.
- IDLE:
  - `ld_ready` = (`wp` < `DEPTH`) and no sealed sequence.
  - An accepted beat writes `buf[wp]`, then `wp++`.
  - `ld_last` on an accepted beat, or `wp` reaching `DEPTH`, seals the sequence: `len` = `wp`+1 (or `DEPTH`). Further loads are refused until `clr`.
  - `start` with `len`>0 → RUN, `pc`=1, outputs = `buf[0]`.
  - `start` with `len`=0 is ignored.
- RUN:
  - Each edge: `pc++`, outputs = `buf[pc]` (0-based slot `pc`).
  - On the edge after `pc==len` is presented → DONE (see Configuration). Outputs go to 0 and `pc` to 0.
  - `start` is ignored. `ld_ready`=0.
- DONE:
  - `done`=1, outputs 0.
  - `start` replays from `pc`=1 with the same buffer.
  - `clr` → IDLE.
- `clr` has priority over `start` in any state. It forces IDLE, `wp`=0, `len`=0, and outputs 0 on the next edge.
- `reset` has priority over everything. Reset mid-RUN aborts playback with all outputs 0 the next cycle.
- `len` counter width is `$clog2(DEPTH+1)`. `pc` is 32 bits and never exceeds `len`.

## Timing
- Start latency: `start` sampled at edge k → `pc`=1 and opcode 1 on the outputs after edge k. Outputs are registered.
- Throughput: one opcode per cycle, no bubbles, with or without looping.
- Load: one beat per cycle at full rate while `ld_ready`=1. The sealing beat drops `ld_ready` on the next cycle.
- `done` rises the cycle after the last opcode is presented.
- `wrap` is high for exactly the cycle in which `pc` returns to 1.

## Configuration
- `CONC_STIM_LOOP_EN` defined:
  - After `pc==len`, the next edge wraps to `pc`=1 with `buf[0]` and pulses `wrap`.
  - RUN exits only via `clr` or `reset`; DONE is unreachable.
- `CONC_STIM_LOOP_EN` undefined:
  - Single pass, as described under Operation.
  - `wrap` is tied 0.

## Test plan
- Load 3 beats 8'hC1, 8'h45, 8'h02 (last on the third), then `start` → next three cycles `pc`=1,2,3:
  - obs/stbi/x_in = 1/1/01, 0/1/05, 0/0/02.
  - Then `done`=1 with outputs and `pc` 0.
- Load 201 beats with no `ld_last` → `ld_ready` drops after beat 201; playback presents all 201 in order, last `pc`=201.
- `start` with nothing loaded, and `start` asserted mid-RUN → no effect; `pc` sequence unchanged.
- Assert `reset` at `pc`=2 of a 5-opcode run → next cycle IDLE with outputs 0 and `pc` 0. A later `start` is ignored because `len`=0.
- In DONE, `start` → sequence replays identically. Then `clr` together with `start` → IDLE and `ld_ready`=1.
- With `CONC_STIM_LOOP_EN`, 2-opcode sequence → `pc` 1,2,1,2,… with `wrap` pulsing on each return to 1; `done` never asserts.
